branch_predictor: RTL



---
 rtl/branch_predictor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for the five-stage pipeline.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              upd_uncond,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              valid_q [ENTRIES];
    logic [1:0]        ctr_q   [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [ADDR_W-1:0] tgt_q   [ENTRIES];

    logic [IDX_W-1:0]  lk_idx, up_idx;
    logic [TAG_W-1:0]  lk_tag, up_tag;
    logic              lk_hit, up_hit;

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not visible yet.
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = lk_hit ? tgt_q[lk_idx] : '0;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    logic       ctr_we, alloc, tgt_we;
    logic [1:0] ctr_d;

    always_comb begin
        ctr_we = 1'b0;
        alloc  = 1'b0;
        tgt_we = 1'b0;
        ctr_d  = ctr_q[up_idx];
        if (upd_valid) begin
            if (up_hit) begin
                ctr_we = 1'b1;
                if (upd_uncond) begin
                    ctr_d  = 2'b11;
                    tgt_we = 1'b1;
                end else if (upd_taken) begin
                    ctr_d  = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    tgt_we = 1'b1;
                end else begin
                    ctr_d  = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken || upd_uncond) begin
                // Not-taken misses never allocate, so they cannot evict a live entry.
                alloc  = 1'b1;
                ctr_we = 1'b1;
                tgt_we = 1'b1;
                ctr_d  = upd_uncond ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            if (ctr_we) ctr_q[up_idx]   <= ctr_d;
            if (alloc)  valid_q[up_idx] <= 1'b1;
        end
    end

    // Tag and target need no reset: they are qualified by valid.
    always_ff @(posedge clk) begin
        if (alloc)  tag_q[up_idx] <= up_tag;
        if (tgt_we) tgt_q[up_idx] <= upd_target;
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] br_q, br_d, mis_q, mis_d;

    always_comb begin
        br_d  = br_q;
        mis_d = mis_q;
        if (upd_valid && br_q != 32'hFFFF_FFFF) br_d = br_q + 32'd1;
        if (upd_valid && upd_mispredict && mis_q != 32'hFFFF_FFFF) mis_d = mis_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            br_q  <= br_d;
            mis_q <= mis_d;
        end
    end

    assign stat_branches = br_q;
    assign stat_mispred  = mis_q;

    logic unused_lowbits;
    assign unused_lowbits = ^{if_pc[1:0], upd_pc[1:0]};
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;

    logic unused_lowbits;
    assign unused_lowbits = ^{if_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif
endmodule
